// File: rtl/pipeline_interlock_if.sv
// pipeline_interlock_if: hazard-unit handshake bundle between the pipeline stages and the interlock.
interface pipeline_interlock_if #(
   parameter int REG_AW = 3,
   parameter int CNT_W  = 16
);
   logic [REG_AW-1:0] id_rs, id_rt, id_rd, ex_rd, wb_long_rd;
   logic id_rs_used, id_rt_used, id_issue_long;
   logic ex_memread, ex_branch_taken, mem_req, mem_ready, wb_long_valid, cnt_clear;
   logic pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush, ex_mem_write;
   logic [CNT_W-1:0] stall_count;

   modport master (
      output id_rs, id_rt, id_rd, id_rs_used, id_rt_used, id_issue_long,
             ex_memread, ex_rd, ex_branch_taken, mem_req, mem_ready,
             wb_long_valid, wb_long_rd, cnt_clear,
      input  pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush,
             ex_mem_write, stall_count
   );

   modport slave (
      input  id_rs, id_rt, id_rd, id_rs_used, id_rt_used, id_issue_long,
             ex_memread, ex_rd, ex_branch_taken, mem_req, mem_ready,
             wb_long_valid, wb_long_rd, cnt_clear,
      output pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush,
             ex_mem_write, stall_count
   );
endinterface

// File: rtl/pipeline_interlock.sv
// pipeline_interlock: load-use/scoreboard stall, memory freeze, branch flush and stall counter.
module pipeline_interlock #(
   parameter int REG_AW   = 3,
   parameter int ZERO_REG = 1,
   parameter int CNT_W    = 16
) (
   input logic clk,
   input logic reset,
   pipeline_interlock_if.slave p
);
   localparam int NREG = 2**REG_AW;

   logic [NREG-1:0]  busy, busy_nxt;
   logic [CNT_W-1:0] cnt;
   logic load_use, sb_haz, haz, freeze, flush, stall, set_ok;

   function automatic logic match(input logic [REG_AW-1:0] a, input logic [REG_AW-1:0] b);
      return (a == b) && !((ZERO_REG != 0) && (a == '0));
   endfunction

   assign load_use = p.ex_memread && ((p.id_rs_used && match(p.ex_rd, p.id_rs)) ||
                                      (p.id_rt_used && match(p.ex_rd, p.id_rt)));
   assign sb_haz   = (p.id_rs_used && busy[p.id_rs]) || (p.id_rt_used && busy[p.id_rt]) ||
                     (p.id_issue_long && busy[p.id_rd]);
   assign haz      = load_use || sb_haz;
   assign freeze   = p.mem_req && !p.mem_ready;
   assign flush    = !reset && !freeze && p.ex_branch_taken;
   assign stall    = !reset && !freeze && !p.ex_branch_taken && haz;

   assign p.pc_write     = !(stall || (!reset && freeze));
   assign p.if_id_write  = p.pc_write;
   assign p.ex_mem_write = reset || !freeze;
   assign p.id_ex_bubble = stall;
   assign p.if_id_flush  = flush;
   assign p.id_ex_flush  = flush;
   assign p.stall_count  = cnt;

   assign set_ok = p.id_issue_long && !freeze && !p.ex_branch_taken && !haz &&
                   !((ZERO_REG != 0) && (p.id_rd == '0));

   // Set is applied after clear so a same-register collision leaves the entry busy.
   always_comb begin
      busy_nxt = busy;
      if (p.wb_long_valid) busy_nxt[p.wb_long_rd] = 1'b0;
      if (set_ok) busy_nxt[p.id_rd] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         busy <= '0;
         cnt  <= '0;
      end else begin
         busy <= busy_nxt;
         if (p.cnt_clear) cnt <= '0;
         else if ((freeze || stall) && cnt != '1) cnt <= cnt + 1'b1;
      end
   end
endmodule

// File: tb/tb_pipeline_interlock.sv
// tb_pipeline_interlock: directed checks of stall, freeze, flush, scoreboard and counter behaviour.
module tb_pipeline_interlock;
   logic clk = 1'b0;
   logic reset;
   int checks = 0;
   int errors = 0;

   localparam logic [5:0] NORM   = 6'b110001;
   localparam logic [5:0] STALL  = 6'b001001;
   localparam logic [5:0] FREEZE = 6'b000000;
   localparam logic [5:0] FLUSH  = 6'b110111;

   always #5 clk = ~clk;

   pipeline_interlock_if #(.REG_AW(3), .CNT_W(16)) ifc ();
   pipeline_interlock_if #(.REG_AW(3), .CNT_W(4))  ifs ();

   pipeline_interlock #(.REG_AW(3), .ZERO_REG(1), .CNT_W(16)) u_dut (.clk(clk), .reset(reset), .p(ifc));
   pipeline_interlock #(.REG_AW(3), .ZERO_REG(1), .CNT_W(4))  u_sat (.clk(clk), .reset(reset), .p(ifs));

   assign ifs.id_rs = ifc.id_rs;
   assign ifs.id_rt = ifc.id_rt;
   assign ifs.id_rd = ifc.id_rd;
   assign ifs.id_rs_used = ifc.id_rs_used;
   assign ifs.id_rt_used = ifc.id_rt_used;
   assign ifs.id_issue_long = ifc.id_issue_long;
   assign ifs.ex_memread = ifc.ex_memread;
   assign ifs.ex_rd = ifc.ex_rd;
   assign ifs.ex_branch_taken = ifc.ex_branch_taken;
   assign ifs.mem_req = ifc.mem_req;
   assign ifs.mem_ready = ifc.mem_ready;
   assign ifs.wb_long_valid = ifc.wb_long_valid;
   assign ifs.wb_long_rd = ifc.wb_long_rd;
   assign ifs.cnt_clear = ifc.cnt_clear;

   wire [5:0] ctl = {ifc.pc_write, ifc.if_id_write, ifc.id_ex_bubble,
                     ifc.if_id_flush, ifc.id_ex_flush, ifc.ex_mem_write};

   task automatic idle();
      ifc.id_rs = 0; ifc.id_rt = 0; ifc.id_rd = 0;
      ifc.id_rs_used = 0; ifc.id_rt_used = 0; ifc.id_issue_long = 0;
      ifc.ex_memread = 0; ifc.ex_rd = 0; ifc.ex_branch_taken = 0;
      ifc.mem_req = 0; ifc.mem_ready = 0; ifc.wb_long_valid = 0; ifc.wb_long_rd = 0;
      ifc.cnt_clear = 0;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #1;
      checks++; if (ctl !== NORM) begin errors++; $display("FAIL reset_ctl: got %b exp %b", ctl, NORM); end
      checks++; if (ifc.stall_count !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d exp 0", ifc.stall_count); end
      checks++; if (u_dut.busy !== 8'h00) begin errors++; $display("FAIL reset_busy: got %h exp 00", u_dut.busy); end
      reset = 0;
      cyc();
   endtask

   task automatic test_load_use();
      ifc.ex_memread = 1; ifc.ex_rd = 3; ifc.id_rs = 3; ifc.id_rs_used = 1; #1;
      checks++; if (ctl !== STALL) begin errors++; $display("FAIL lu_stall: got %b exp %b", ctl, STALL); end
      cyc();
      ifc.ex_memread = 0; #1;
      checks++; if (ctl !== NORM) begin errors++; $display("FAIL lu_release: got %b exp %b", ctl, NORM); end
      checks++; if (ifc.stall_count !== 16'd1) begin errors++; $display("FAIL lu_cnt: got %0d exp 1", ifc.stall_count); end
      ifc.ex_memread = 1; ifc.ex_rd = 0; ifc.id_rs = 0; #1;
      checks++; if (ctl !== NORM) begin errors++; $display("FAIL lu_zero: got %b exp %b", ctl, NORM); end
      ifc.id_rt = 3; ifc.id_rt_used = 1; ifc.ex_rd = 3; #1;
      checks++; if (ctl !== STALL) begin errors++; $display("FAIL lu_rt: got %b exp %b", ctl, STALL); end
      idle();
      ifc.cnt_clear = 1;
      cyc();
      ifc.cnt_clear = 0;
      checks++; if (ifc.stall_count !== 16'd0) begin errors++; $display("FAIL lu_clear: got %0d exp 0", ifc.stall_count); end
   endtask

   task automatic test_scoreboard();
      ifc.id_issue_long = 1; ifc.id_rd = 5; #1;
      checks++; if (ctl !== NORM) begin errors++; $display("FAIL sb_issue: got %b exp %b", ctl, NORM); end
      cyc();
      checks++; if (u_dut.busy !== 8'h20) begin errors++; $display("FAIL sb_busy: got %h exp 20", u_dut.busy); end
      ifc.id_issue_long = 0; ifc.id_rd = 0; ifc.id_rs = 5; ifc.id_rs_used = 1; #1;
      checks++; if (ctl !== STALL) begin errors++; $display("FAIL sb_stall: got %b exp %b", ctl, STALL); end
      cyc();
      cyc();
      ifc.wb_long_valid = 1; ifc.wb_long_rd = 5; #1;
      checks++; if (ctl !== STALL) begin errors++; $display("FAIL sb_wb_cycle: got %b exp %b", ctl, STALL); end
      cyc();
      ifc.wb_long_valid = 0; #1;
      checks++; if (ctl !== NORM) begin errors++; $display("FAIL sb_release: got %b exp %b", ctl, NORM); end
      checks++; if (ifc.stall_count !== 16'd3) begin errors++; $display("FAIL sb_cnt: got %0d exp 3", ifc.stall_count); end
      checks++; if (u_dut.busy !== 8'h00) begin errors++; $display("FAIL sb_cleared: got %h exp 00", u_dut.busy); end
      idle();
   endtask

   task automatic test_waw();
      ifc.id_issue_long = 1; ifc.id_rd = 2;
      cyc();
      #1;
      checks++; if (ctl !== STALL) begin errors++; $display("FAIL waw_stall: got %b exp %b", ctl, STALL); end
      cyc();
      checks++; if (u_dut.busy !== 8'h04) begin errors++; $display("FAIL waw_busy: got %h exp 04", u_dut.busy); end
      ifc.id_issue_long = 0; ifc.wb_long_valid = 1; ifc.wb_long_rd = 2;
      cyc();
      ifc.id_issue_long = 1; ifc.id_rd = 4; ifc.wb_long_rd = 4; #1;
      checks++; if (ctl !== NORM) begin errors++; $display("FAIL setclr_ctl: got %b exp %b", ctl, NORM); end
      cyc();
      checks++; if (u_dut.busy !== 8'h10) begin errors++; $display("FAIL setclr_busy: got %h exp 10", u_dut.busy); end
      ifc.id_issue_long = 0;
      cyc();
      checks++; if (ifc.stall_count !== 16'd4) begin errors++; $display("FAIL waw_cnt: got %0d exp 4", ifc.stall_count); end
      idle();
   endtask

   task automatic test_priority();
      ifc.mem_req = 1; ifc.ex_branch_taken = 1;
      ifc.ex_memread = 1; ifc.ex_rd = 3; ifc.id_rs = 3; ifc.id_rs_used = 1; #1;
      checks++; if (ctl !== FREEZE) begin errors++; $display("FAIL pri_freeze: got %b exp %b", ctl, FREEZE); end
      cyc();
      checks++; if (ifc.stall_count !== 16'd5) begin errors++; $display("FAIL pri_freeze_cnt: got %0d exp 5", ifc.stall_count); end
      ifc.mem_req = 0; ifc.id_issue_long = 1; ifc.id_rd = 6; #1;
      checks++; if (ctl !== FLUSH) begin errors++; $display("FAIL pri_flush: got %b exp %b", ctl, FLUSH); end
      cyc();
      checks++; if (ifc.stall_count !== 16'd5) begin errors++; $display("FAIL pri_flush_cnt: got %0d exp 5", ifc.stall_count); end
      checks++; if (u_dut.busy !== 8'h00) begin errors++; $display("FAIL pri_flush_busy: got %h exp 00", u_dut.busy); end
      idle();
   endtask

   task automatic test_saturate();
      ifc.cnt_clear = 1;
      cyc();
      ifc.cnt_clear = 0;
      ifc.mem_req = 1;
      repeat (20) cyc();
      checks++; if (ifs.stall_count !== 4'd15) begin errors++; $display("FAIL sat_cnt4: got %0d exp 15", ifs.stall_count); end
      checks++; if (ifc.stall_count !== 16'd20) begin errors++; $display("FAIL sat_cnt16: got %0d exp 20", ifc.stall_count); end
      ifc.mem_ready = 1; #1;
      checks++; if (ctl !== NORM) begin errors++; $display("FAIL sat_ready: got %b exp %b", ctl, NORM); end
      ifc.mem_ready = 0; ifc.cnt_clear = 1;
      cyc();
      ifc.cnt_clear = 0;
      checks++; if (ifs.stall_count !== 4'd0 || ifc.stall_count !== 16'd0) begin
         errors++; $display("FAIL sat_clear: got %0d/%0d exp 0/0", ifs.stall_count, ifc.stall_count);
      end
      idle();
   endtask

   task automatic test_reset_mid();
      ifc.id_issue_long = 1;
      ifc.id_rd = 1; cyc();
      ifc.id_rd = 3; cyc();
      ifc.id_rd = 7; cyc();
      ifc.id_issue_long = 0;
      checks++; if (u_dut.busy !== 8'h8A) begin errors++; $display("FAIL mid_busy: got %h exp 8a", u_dut.busy); end
      ifc.mem_req = 1;
      cyc();
      checks++; if (ifc.stall_count !== 16'd1) begin errors++; $display("FAIL mid_cnt: got %0d exp 1", ifc.stall_count); end
      ifc.ex_branch_taken = 1; reset = 1; #1;
      checks++; if (ctl !== NORM) begin errors++; $display("FAIL mid_ctl: got %b exp %b", ctl, NORM); end
      cyc();
      checks++; if (u_dut.busy !== 8'h00) begin errors++; $display("FAIL mid_busy_clr: got %h exp 00", u_dut.busy); end
      checks++; if (ifc.stall_count !== 16'd0) begin errors++; $display("FAIL mid_cnt_clr: got %0d exp 0", ifc.stall_count); end
      reset = 0;
      idle();
   endtask

   initial begin
      reset = 1;
      idle();
      repeat (2) @(posedge clk);
      test_reset();
      test_load_use();
      test_scoreboard();
      test_waw();
      test_priority();
      test_saturate();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
